cpu_gpio_bank: RTL and testbench

- Parametrised GPIO peripheral for the PIC10-compatible CPU.
- Generalises the fixed three 1-bit GPIO/TRIS pairs in the CPU top into NUM_PORTS ports of WIDTH bits each.
- Adds new behaviour:
  - two-flop input synchronisation;
  - registered read-back;
  - per-bit interrupt-on-change (IOC) with sticky write-1-to-clear flags and an irq output.
- Sits on the datapath register bus, alongside RAM and FSR.

---
 rtl/cpu_gpio_pkg.sv | 15 +
 rtl/cpu_gpio_channel.sv | 79 +++++++
 rtl/cpu_gpio_bank.sv | 69 ++++++
 tb/tb_cpu_gpio_bank.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_gpio_pkg.sv
// Shared definitions for the CPU GPIO bank: register-select encodings and
// reset constants used by the bank top and its per-port channels.
package cpu_gpio_pkg;

  typedef enum logic [1:0] {
    REG_GPIO    = 2'd0,
    REG_TRIS    = 2'd1,
    REG_IOCEN   = 2'd2,
    REG_IOCFLAG = 2'd3
  } reg_sel_e;

  // Every pin comes out of reset as an input; replicate per channel width.
  localparam logic TRIS_RESET_BIT = 1'b1;

endpackage

// File: rtl/cpu_gpio_channel.sv
// One WIDTH-bit GPIO port: direction/latch/IOC registers, two-flop input
// synchroniser, tristate pin drivers and the per-port read mux.
module cpu_gpio_channel
  import cpu_gpio_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  reg_sel_e         reg_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_val,
  output logic             flag_any,
  inout  wire  [WIDTH-1:0] pin
);

  logic [WIDTH-1:0] tris;
  logic [WIDTH-1:0] latch;
  logic [WIDTH-1:0] iocen;
  logic [WIDTH-1:0] flag;
  logic [WIDTH-1:0] snapshot;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] hit;

  // tris resets to inputs asynchronously, so pins float for the whole reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pin[i] = tris[i] ? 1'bz : latch[i];
  end

  assign clr      = (wr && reg_sel == REG_IOCFLAG) ? wr_data : '0;
  assign hit      = iocen & (pin_s ^ snapshot);
  assign flag_any = |flag;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; hit therefore sees the snapshot from before a same-edge read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tris     <= {WIDTH{TRIS_RESET_BIT}};
      latch    <= '0;
      iocen    <= '0;
      flag     <= '0;
      snapshot <= '0;
      sync1    <= '0;
      pin_s    <= '0;
    end else begin
      sync1 <= pin;
      pin_s <= sync1;
      // Set is ORed in after the clear, so a same-edge set wins over W1C.
      flag  <= (flag & ~clr) | hit;
      if (rd && reg_sel == REG_GPIO) snapshot <= pin_s;
      if (wr) begin
        case (reg_sel)
          REG_GPIO:  latch <= wr_data;
          REG_TRIS:  tris  <= wr_data;
          REG_IOCEN: iocen <= wr_data;
          default:   ;
        endcase
      end
    end
  end

  // NOTE: rd_val gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_GPIO:    rd_val = pin_s;
      REG_TRIS:    rd_val = tris;
      REG_IOCEN:   rd_val = iocen;
      REG_IOCFLAG: rd_val = flag;
      default:     rd_val = '0;
    endcase
  end

endmodule

// File: rtl/cpu_gpio_bank.sv
// GPIO peripheral on the CPU register bus: NUM_PORTS ports of WIDTH bits,
// port decode, registered read-back and a registered IOC interrupt.
module cpu_gpio_bank
  import cpu_gpio_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int WIDTH     = 1,
  parameter int PSEL_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PSEL_W-1:0]          port_sel,
  input  logic [1:0]                 reg_sel,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  inout  wire  [NUM_PORTS*WIDTH-1:0] gpio_bus,
  output logic                       irq
);

  logic [WIDTH-1:0]     ch_rd [NUM_PORTS];
  logic [NUM_PORTS-1:0] ch_flag;
  logic [NUM_PORTS-1:0] port_hit;
  logic [WIDTH-1:0]     rd_next;
  logic                 sel_ok;
  reg_sel_e             reg_kind;

  // Compared at 32 bits so NUM_PORTS == 2**PSEL_W does not wrap to zero.
  assign sel_ok   = 32'(port_sel) < NUM_PORTS;
  assign reg_kind = reg_sel_e'(reg_sel);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_hit[p] = sel_ok && (port_sel == PSEL_W'(p));

    cpu_gpio_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_en && port_hit[p]),
      .rd       (rd_en && port_hit[p]),
      .reg_sel  (reg_kind),
      .wr_data  (wr_data),
      .rd_val   (ch_rd[p]),
      .flag_any (ch_flag[p]),
      .pin      (gpio_bus[p*WIDTH +: WIDTH])
    );
  end

  // Out-of-range selects match no port and so read back as zero.
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_hit[p]) rd_next = ch_rd[p];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      irq     <= 1'b0;
    end else begin
      if (rd_en) rd_data <= rd_next;
      irq <= |ch_flag;
    end
  end

endmodule

// File: tb/tb_cpu_gpio_bank.sv
// Self-checking bench for cpu_gpio_bank: directed steps plus random traffic
// against an array-level reference model; a second wide instance for width cases.
module tb_cpu_gpio_bank;
  import cpu_gpio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default-configuration DUT (3 ports x 1 bit)
  logic [1:0] port_sel;
  logic [1:0] reg_sel;
  logic       wr_en, rd_en, wr_data;
  logic       rd_data, irq;
  wire  [2:0] gpio_bus;
  logic [2:0] ext_en, ext_val;

  // Pull-ups make an undriven pin read 1, so "floating" is observable.
  for (genvar i = 0; i < 3; i++) begin : g_ext
    pullup pu (gpio_bus[i]);
    assign gpio_bus[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  cpu_gpio_bank u_dut (
    .clk      (clk),
    .rst      (rst),
    .port_sel (port_sel),
    .reg_sel  (reg_sel),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .gpio_bus (gpio_bus),
    .irq      (irq)
  );

  // Wide DUT (4 ports x 8 bits, 3-bit select)
  logic [2:0]  w_port_sel;
  logic [1:0]  w_reg_sel;
  logic        w_wr_en, w_rd_en;
  logic [7:0]  w_wr_data, w_rd_data;
  logic        w_irq;
  wire  [31:0] w_bus;

  for (genvar i = 0; i < 32; i++) begin : g_wpu
    pullup pu (w_bus[i]);
  end

  cpu_gpio_bank #(.NUM_PORTS(4), .WIDTH(8), .PSEL_W(3)) u_wide (
    .clk      (clk),
    .rst      (rst),
    .port_sel (w_port_sel),
    .reg_sel  (w_reg_sel),
    .wr_en    (w_wr_en),
    .rd_en    (w_rd_en),
    .wr_data  (w_wr_data),
    .rd_data  (w_rd_data),
    .gpio_bus (w_bus),
    .irq      (w_irq)
  );

  // Reference model of the default DUT, one array element per port.
  // pin_hist[0] is the pin value seen one edge ago, pin_hist[1] two edges ago.
  logic [2:0] m_tris, m_latch, m_ioen, m_flag, m_snap;
  logic [2:0] pin_hist [2];
  logic       m_rd, m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tris      = 3'b111;
    m_latch     = '0;
    m_ioen      = '0;
    m_flag      = '0;
    m_snap      = '0;
    pin_hist[0] = '0;
    pin_hist[1] = '0;
    m_rd        = 1'b0;
    m_irq       = 1'b0;
  endtask

  function automatic logic [2:0] pins_now();
    logic [2:0] v;
    for (int b = 0; b < 3; b++)
      v[b] = m_tris[b] ? (ext_en[b] ? ext_val[b] : 1'b1) : m_latch[b];
    return v;
  endfunction

  // One clock edge: predict from pre-edge state and inputs, advance, compare.
  task automatic step();
    logic [2:0] pin, n_tris, n_latch, n_ioen, n_flag, n_snap, clr;
    logic       n_rd, n_irq;
    int         p;
    bit         ok;
    p       = int'(port_sel);
    ok      = (p < 3);
    pin     = pins_now();
    n_tris  = m_tris;
    n_latch = m_latch;
    n_ioen  = m_ioen;
    n_snap  = m_snap;
    n_rd    = m_rd;
    clr     = '0;
    if (rd_en) begin
      n_rd = 1'b0;
      if (ok) begin
        case (reg_sel)
          REG_GPIO:    n_rd = pin_hist[1][p];
          REG_TRIS:    n_rd = m_tris[p];
          REG_IOCEN:   n_rd = m_ioen[p];
          default:     n_rd = m_flag[p];
        endcase
        if (reg_sel == REG_GPIO) n_snap[p] = pin_hist[1][p];
      end
    end
    if (wr_en && ok) begin
      case (reg_sel)
        REG_GPIO:  n_latch[p] = wr_data;
        REG_TRIS:  n_tris[p]  = wr_data;
        REG_IOCEN: n_ioen[p]  = wr_data;
        default:   clr[p]     = wr_data;
      endcase
    end
    n_flag = (m_flag & ~clr) | (m_ioen & (pin_hist[1] ^ m_snap));
    n_irq  = |m_flag;
    @(posedge clk);
    #1;
    pin_hist[1] = pin_hist[0];
    pin_hist[0] = pin;
    m_tris  = n_tris;
    m_latch = n_latch;
    m_ioen  = n_ioen;
    m_flag  = n_flag;
    m_snap  = n_snap;
    m_rd    = n_rd;
    m_irq   = n_irq;
    ext_en  = ext_en & m_tris;
    #1;
    check("rd_data", 32'(rd_data), 32'(m_rd));
    check("irq", 32'(irq), 32'(m_irq));
    check("pins", 32'(gpio_bus), 32'(pins_now()));
  endtask

  task automatic op(input logic [1:0] ps, input logic [1:0] rs,
                    input logic we, input logic re, input logic wd);
    port_sel = ps;
    reg_sel  = rs;
    wr_en    = we;
    rd_en    = re;
    wr_data  = wd;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic wop(input logic [2:0] ps, input logic [1:0] rs,
                     input logic we, input logic re, input logic [7:0] wd);
    w_port_sel = ps;
    w_reg_sel  = rs;
    w_wr_en    = we;
    w_rd_en    = re;
    w_wr_data  = wd;
    step();
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
  endtask

  initial begin
    port_sel = '0; reg_sel = '0; wr_en = 0; rd_en = 0; wr_data = 0;
    ext_en = '0; ext_val = '0;
    w_port_sel = '0; w_reg_sel = '0; w_wr_en = 0; w_rd_en = 0; w_wr_data = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pins", 32'(gpio_bus), 32'h7);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rd", 32'(rd_data), 32'h0);
    check("rst_wide_pins", w_bus, 32'hFFFF_FFFF);
    rst = 1'b1;

    op(2'd0, REG_TRIS, 0, 1, 0);
    check("tris_p0_default", 32'(rd_data), 32'h1);

    // Output drive on port 1
    op(2'd1, REG_TRIS, 1, 0, 0);
    check("p1_drive_0", 32'(gpio_bus[1]), 32'h0);
    op(2'd1, REG_GPIO, 1, 0, 1);
    check("p1_drive_1", 32'(gpio_bus[1]), 32'h1);
    step(); step();
    op(2'd1, REG_GPIO, 0, 1, 0);
    check("p1_readback", 32'(rd_data), 32'h1);
    op(2'd1, REG_GPIO, 1, 0, 0);
    check("p1_drive_0b", 32'(gpio_bus[1]), 32'h0);
    op(2'd1, REG_TRIS, 1, 0, 1);
    check("p1_released", 32'(gpio_bus[1]), 32'h1);

    // Interrupt-on-change on port 2
    ext_en[2] = 1'b1; ext_val[2] = 1'b0;
    step(); step(); step();
    op(2'd2, REG_IOCEN, 1, 0, 1);
    op(2'd2, REG_GPIO, 0, 1, 0);
    check("p2_snapshot_rd", 32'(rd_data), 32'h0);
    ext_val[2] = 1'b1;
    step(); step(); step();
    check("irq_before_t4", 32'(irq), 32'h0);
    op(2'd2, REG_IOCFLAG, 0, 1, 0);
    check("flag_set", 32'(rd_data), 32'h1);
    check("irq_at_t4", 32'(irq), 32'h1);
    op(2'd2, REG_IOCFLAG, 1, 0, 1);
    op(2'd2, REG_IOCFLAG, 0, 1, 0);
    check("set_beats_w1c", 32'(rd_data), 32'h1);
    op(2'd2, REG_GPIO, 0, 1, 0);
    check("p2_rearm_rd", 32'(rd_data), 32'h1);
    op(2'd2, REG_IOCFLAG, 1, 0, 1);
    check("irq_lags_clear", 32'(irq), 32'h1);
    step();
    check("irq_cleared", 32'(irq), 32'h0);
    op(2'd2, REG_IOCFLAG, 0, 1, 0);
    check("flag_cleared", 32'(rd_data), 32'h0);

    // Wide instance: mixed direction and out-of-range select
    wop(3'd3, REG_TRIS, 1, 0, 8'h0F);
    wop(3'd3, REG_GPIO, 1, 0, 8'hA5);
    check("wide_p3_pins", 32'(w_bus[31:24]), 32'hAF);
    check("wide_low_pins", 32'(w_bus[23:0]), 32'hFF_FFFF);
    wop(3'd3, REG_TRIS, 0, 1, 8'h00);
    check("wide_tris_p3", 32'(w_rd_data), 32'h0F);
    wop(3'd4, REG_TRIS, 0, 1, 8'h00);
    check("wide_oor_read", 32'(w_rd_data), 32'h0);
    wop(3'd4, REG_TRIS, 1, 0, 8'h00);
    wop(3'd4, REG_GPIO, 1, 0, 8'h00);
    check("wide_oor_write", w_bus, 32'hAFFF_FFFF);
    wop(3'd0, REG_TRIS, 0, 1, 8'h00);
    check("wide_tris_p0", 32'(w_rd_data), 32'hFF);
    check("wide_irq", 32'(w_irq), 32'h0);

    // Asynchronous reset with a flag pending and port 0 driving
    op(2'd0, REG_TRIS, 1, 0, 0);
    check("p0_driven", 32'(gpio_bus[0]), 32'h0);
    ext_val[2] = 1'b0;
    repeat (4) step();
    check("irq_before_rst", 32'(irq), 32'h1);
    #3;
    ext_en = '0;
    rst = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'h0);
    check("async_pins", 32'(gpio_bus), 32'h7);
    check("async_wide_pins", w_bus, 32'hFFFF_FFFF);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    op(2'd0, REG_TRIS, 0, 1, 0);
    check("post_rst_tris", 32'(rd_data), 32'h1);
    op(2'd2, REG_IOCFLAG, 0, 1, 0);
    check("post_rst_flag", 32'(rd_data), 32'h0);
    op(2'd2, REG_IOCEN, 0, 1, 0);
    check("post_rst_iocen", 32'(rd_data), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      port_sel = 2'($urandom_range(0, 3));
      reg_sel  = 2'($urandom_range(0, 3));
      wr_en    = ($urandom_range(0, 2) == 0);
      rd_en    = ($urandom_range(0, 1) == 0);
      wr_data  = 1'($urandom);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) ext_val[b] = ~ext_val[b];
      ext_en = 3'($urandom) & m_tris;
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
